// File: rtl/barrett_param_if.sv
// Modulus-in / Barrett-constants-out handshake bundle between the config shell and barrett_param_gen.
interface barrett_param_if #(
    parameter int unsigned MAX_BIT_WIDTH = 54
);
    logic                     in_valid;
    logic                     in_ready;
    logic [MAX_BIT_WIDTH-1:0] q_in;
    logic                     out_valid;
    logic                     out_ready;
    logic [MAX_BIT_WIDTH-1:0] q_out;
    logic [MAX_BIT_WIDTH:0]   m;
    logic [6:0]               k2;
    logic                     k2_ok;
    logic                     err;

    modport master (
        output in_valid, q_in, out_ready,
        input  in_ready, out_valid, q_out, m, k2, k2_ok, err
    );

    modport slave (
        input  in_valid, q_in, out_ready,
        output in_ready, out_valid, q_out, m, k2, k2_ok, err
    );
endinterface

// File: rtl/barrett_param_gen.sv
// Computes Barrett constants m = floor(2^(2k)/q), k2 = 2k for a modulus q using a
// bit-serial restoring divider; results are held on a valid/ready output.
module barrett_param_gen #(
    parameter int unsigned MAX_BIT_WIDTH = 54
) (
    input  logic           clk,
    input  logic           rst,
    barrett_param_if.slave bus
);
    localparam int unsigned W  = MAX_BIT_WIDTH;
    localparam int unsigned KW = 7;

    typedef enum logic [1:0] {IDLE, CALC_K, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    q_q, q_d;
    logic [KW-1:0]   k2_q, k2_d;
    logic            k2_ok_q, k2_ok_d;
    logic [W:0]      r_q, r_d;
    logic [W+1:0]    quo_q, quo_d;
    logic [KW-1:0]   cnt_q, cnt_d;

    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [W-1:0]    q_out_q, q_out_d;
    logic [W:0]      m_q, m_d;
    logic [KW-1:0]   k2_out_q, k2_out_d;
    logic            k2_ok_out_q, k2_ok_out_d;
    logic            err_q, err_d;

    // k = position of the most significant set bit plus one
    function automatic logic [KW-1:0] msb_plus_one(input logic [W-1:0] v);
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < int'(W); i++) begin
            if (v[i]) k = KW'(i + 1);
        end
        return k;
    endfunction

    function automatic logic k2_supported(input logic [KW-1:0] v);
        return (v == KW'(54)) || (v == KW'(58)) || (v == KW'(70)) ||
               (v == KW'(74)) || (v == KW'(100)) || (v == KW'(108));
    endfunction

    logic [KW-1:0] k_calc;
    logic [KW-1:0] k2_calc;
    logic          q_bad;
    assign k_calc  = msb_plus_one(q_q);
    assign k2_calc = KW'(k_calc << 1);
    assign q_bad   = (q_q < W'(2)) || ((q_q & (q_q - W'(1))) == '0);

    // One restoring-division step; the dividend is a single 1 followed by 2k zeros
    logic          div_bit;
    logic [W+1:0]  t;
    logic [W+1:0]  q_ext;
    logic          ge;
    logic [W:0]    r_next;
    logic [W+1:0]  quo_next;
    assign div_bit  = (cnt_q == k2_q);
    assign t        = {r_q, div_bit};
    assign q_ext    = (W+2)'(q_q);
    assign ge       = (t >= q_ext);
    assign r_next   = ge ? (W+1)'(t - q_ext) : (W+1)'(t);
    assign quo_next = (W+2)'({quo_q, ge});

    always_comb begin
        state_d     = state_q;
        q_d         = q_q;
        k2_d        = k2_q;
        k2_ok_d     = k2_ok_q;
        r_d         = r_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        q_out_d     = q_out_q;
        m_d         = m_q;
        k2_out_d    = k2_out_q;
        k2_ok_out_d = k2_ok_out_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    q_d        = bus.q_in;
                    in_ready_d = 1'b0;
                    state_d    = CALC_K;
                end
            end
            CALC_K: begin
                if (q_bad) begin
                    q_out_d     = q_q;
                    m_d         = '0;
                    k2_out_d    = '0;
                    k2_ok_out_d = 1'b0;
                    err_d       = 1'b1;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    k2_d    = k2_calc;
                    k2_ok_d = k2_supported(k2_calc);
                    r_d     = '0;
                    quo_d   = '0;
                    cnt_d   = k2_calc;
                    state_d = DIV;
                end
            end
            DIV: begin
                r_d   = r_next;
                quo_d = quo_next;
                if (cnt_q == '0) begin
                    q_out_d     = q_q;
                    m_d         = (W+1)'(quo_next);
                    k2_out_d    = k2_q;
                    k2_ok_out_d = k2_ok_q;
                    err_d       = 1'b0;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q - KW'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            q_q         <= '0;
            k2_q        <= '0;
            k2_ok_q     <= 1'b0;
            r_q         <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            q_out_q     <= '0;
            m_q         <= '0;
            k2_out_q    <= '0;
            k2_ok_out_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_q         <= q_d;
            k2_q        <= k2_d;
            k2_ok_q     <= k2_ok_d;
            r_q         <= r_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            q_out_q     <= q_out_d;
            m_q         <= m_d;
            k2_out_q    <= k2_out_d;
            k2_ok_out_q <= k2_ok_out_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.q_out     = q_out_q;
    assign bus.m         = m_q;
    assign bus.k2        = k2_out_q;
    assign bus.k2_ok     = k2_ok_out_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_barrett_param_gen.sv
// Directed and random checks of barrett_param_gen against an arithmetic model of
// floor(2^(2k)/q), plus Barrett reductions using the produced constants.
module tb_barrett_param_gen;
    localparam int unsigned W = 54;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    barrett_param_if #(.MAX_BIT_WIDTH(W)) bus ();

    barrett_param_gen #(.MAX_BIT_WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected constants straight from the definition
    task automatic model(input logic [W-1:0] q, output logic [W:0] m_e, output logic [6:0] k2_e,
                         output logic ok_e, output logic err_e, output int lat_e);
        int k;
        logic [127:0] num;
        err_e = (q < 2) || ($countones(q) == 1);
        if (err_e) begin
            m_e = '0; k2_e = '0; ok_e = 1'b0; lat_e = 2;
        end else begin
            k     = $clog2(128'(q) + 128'd1);
            k2_e  = 7'(2 * k);
            num   = 128'd1 << (2 * k);
            m_e   = (W+1)'(num / 128'(q));
            ok_e  = ((2 * k) inside {54, 58, 70, 74, 100, 108});
            lat_e = 2 * k + 3;
        end
    endtask

    task automatic barrett_check(input logic [W-1:0] q);
        logic [255:0] a, b, x, qh, rr;
        for (int i = 0; i < 2; i++) begin
            a  = 256'({$urandom(), $urandom()} % 64'(q));
            b  = 256'({$urandom(), $urandom()} % 64'(q));
            if (i == 0) begin a = 256'(q) - 1; b = 256'(q) - 1; end
            x  = a * b;
            qh = (x * 256'(bus.m)) >> bus.k2;
            rr = x - qh * 256'(q);
            if (rr >= 256'(q)) rr = rr - 256'(q);
            if (rr >= 256'(q)) rr = rr - 256'(q);
            check("barrett_mod", rr, x % 256'(q));
        end
    endtask

    task automatic run_q(input logic [W-1:0] q, input bit pulse, input int hold);
        logic [W:0] m_e;
        logic [6:0] k2_e;
        logic       ok_e, err_e;
        int         lat_e, lat, n;
        bit         got;
        model(q, m_e, k2_e, ok_e, err_e, lat_e);
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        bus.in_valid = 1'b1;
        bus.q_in     = q;
        lat = 0;
        got = 1'b0;
        while (lat < 250 && !got) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            bus.in_valid = pulse && lat >= 3 && lat <= 6;
            bus.q_in     = pulse ? W'(5) : q;
            if (lat == 1) check("in_ready_busy", 256'(bus.in_ready), 256'(0));
            if (bus.out_valid === 1'b1) got = 1'b1;
        end
        bus.in_valid = 1'b0;
        check("latency", 256'(lat), 256'(lat_e));
        check("q_out", 256'(bus.q_out), 256'(q));
        check("m", 256'(bus.m), 256'(m_e));
        check("k2", 256'(bus.k2), 256'(k2_e));
        check("k2_ok", 256'(bus.k2_ok), 256'(ok_e));
        check("err", 256'(bus.err), 256'(err_e));
        if (got && !err_e) barrett_check(q);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            check("hold_valid", 256'(bus.out_valid), 256'(1));
            check("hold_in_ready", 256'(bus.in_ready), 256'(0));
            check("hold_m", 256'(bus.m), 256'(m_e));
            check("hold_k2", 256'(bus.k2), 256'(k2_e));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.out_ready = 1'b0;
        check("post_hs_valid", 256'(bus.out_valid), 256'(0));
        check("post_hs_in_ready", 256'(bus.in_ready), 256'(1));
    endtask

    initial begin
        logic [W-1:0] q;
        logic [63:0]  rnd;
        int           k;
        vectors      = 0;
        miscompares  = 0;
        clk          = 1'b0;
        rst          = 1'b1;
        bus.in_valid  = 1'b0;
        bus.q_in      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 256'(bus.in_ready), 256'(1));
        check("rst_out_valid", 256'(bus.out_valid), 256'(0));
        check("rst_m", 256'(bus.m), 256'(0));
        check("rst_k2", 256'(bus.k2), 256'(0));
        check("rst_err", 256'(bus.err), 256'(0));
        rst = 1'b0;
        @(negedge clk);

        run_q({W{1'b1}}, 1'b0, 0);
        run_q(W'(12289), 1'b1, 5);
        run_q(W'(7), 1'b0, 0);
        run_q(W'(3), 1'b0, 1);
        run_q(W'(0), 1'b0, 0);
        run_q(W'(1), 1'b0, 2);
        run_q(W'(1) << 53, 1'b0, 0);
        run_q(W'(64), 1'b0, 0);

        // Abort a long computation with reset mid-divide
        bus.in_valid = 1'b1;
        bus.q_in     = {W{1'b1}};
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("abort_out_valid", 256'(bus.out_valid), 256'(0));
        check("abort_in_ready", 256'(bus.in_ready), 256'(1));
        check("abort_m", 256'(bus.m), 256'(0));
        check("abort_q_out", 256'(bus.q_out), 256'(0));
        check("abort_k2", 256'(bus.k2), 256'(0));
        check("abort_k2_ok", 256'(bus.k2_ok), 256'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_q(W'(12289), 1'b0, 0);

        for (int v = 0; v < 300; v++) begin
            k   = int'($urandom_range(2, W));
            rnd = {$urandom(), $urandom()};
            q   = W'(rnd) & ((W'(1) << k) - W'(1));
            q   = q | (W'(1) << (k - 1));
            if ($countones(q) == 1) q = q | W'(1);
            run_q(q, v[3], int'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
